// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 1024;
    localparam logic [31:0] ARB_TIMEOUT_DATA    = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way pick: a sole requester wins, a tie goes to the pointer.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one native-bus slave between two masters,
// one whole transaction at a time, with a watchdog that ends hung accesses.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TimeoutCycles = ARB_TIMEOUT_DEFAULT,
    parameter logic [31:0] TimeoutData   = ARB_TIMEOUT_DATA
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        m0_valid_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wstrb_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ready_o,
    input  logic        m1_valid_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wstrb_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ready_o,
    output logic        s_valid_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_wstrb_o,
    input  logic [31:0] s_rdata_i,
    input  logic        s_ready_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam int unsigned     CntW     = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast  = CntW'(TimeoutCycles - 1);

    arb_state_e      state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    logic [1:0]  req_vec;
    logic [1:0]  pick;
    mem_req_t    m0_req, m1_req, sel_req;
    logic        busy, gnt_valid, done_ok, done_to, finish;
    logic [1:0]  ready_vec;
    logic [31:0] rdata_sel;

    assign req_vec = {m1_valid_i, m0_valid_i};
    assign m0_req  = {m0_addr_i, m0_wdata_i, m0_wstrb_i};
    assign m1_req  = {m1_addr_i, m1_wdata_i, m1_wstrb_i};
    assign sel_req = grant_q[1] ? m1_req : m0_req;

    rr_arbiter_2 u_pick (
        .req_i (req_vec),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    // A completion only counts while the granted master still holds its request;
    // a slave ready on the expiry cycle beats the watchdog.
    assign busy      = (state_q == ARB_BUSY);
    assign gnt_valid = |(grant_q & req_vec);
    assign done_ok   = busy && gnt_valid && s_ready_i;
    assign done_to   = busy && gnt_valid && !s_ready_i && (cnt_q == CntLast);
    assign finish    = done_ok || done_to;
    assign ready_vec = grant_q & {2{finish}};
    assign rdata_sel = done_ok ? s_rdata_i : TimeoutData;

    assign m0_ready_o = ready_vec[0];
    assign m1_ready_o = ready_vec[1];
    assign m0_rdata_o = ready_vec[0] ? rdata_sel : 32'h0;
    assign m1_rdata_o = ready_vec[1] ? rdata_sel : 32'h0;

    assign s_valid_o = busy;
    assign s_addr_o  = busy ? sel_req.addr  : 32'h0;
    assign s_wdata_o = busy ? sel_req.wdata : 32'h0;
    assign s_wstrb_o = busy ? sel_req.wstrb : 4'h0;
    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q || done_to;
        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (|req_vec) begin
                    state_d = ARB_BUSY;
                    grant_d = pick;
                end
            end
            ARB_BUSY: begin
                if (!gnt_valid) begin
                    state_d = ARB_IDLE;
                    grant_d = 2'b00;
                    cnt_d   = '0;
                end else if (finish) begin
                    state_d = ARB_IDLE;
                    grant_d = 2'b00;
                    cnt_d   = '0;
                    ptr_d   = grant_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = 2'b00;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ARB_IDLE;
            grant_q   <= 2'b00;
            ptr_q     <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level
// model of the arbitration, completion and watchdog rules.
module tb_mem_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata = '0;
    logic        s_ready = 1'b0;
    logic [1:0]  grant;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int pref = 0;
    bit to_sticky = 1'b0;

    mem_bus_arbiter #(.TimeoutCycles(TO)) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .m0_valid_i (m0_valid),
        .m0_addr_i  (m0_addr),
        .m0_wdata_i (m0_wdata),
        .m0_wstrb_i (m0_wstrb),
        .m0_rdata_o (m0_rdata),
        .m0_ready_o (m0_ready),
        .m1_valid_i (m1_valid),
        .m1_addr_i  (m1_addr),
        .m1_wdata_i (m1_wdata),
        .m1_wstrb_i (m1_wstrb),
        .m1_rdata_o (m1_rdata),
        .m1_ready_o (m1_ready),
        .s_valid_o  (s_valid),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_wstrb_o  (s_wstrb),
        .s_rdata_i  (s_rdata),
        .s_ready_i  (s_ready),
        .grant_o    (grant),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int m);
        if (m == 0) begin
            m0_addr  = $urandom;
            m0_wdata = $urandom;
            m0_wstrb = 4'($urandom_range(0, 15));
        end else begin
            m1_addr  = $urandom;
            m1_wdata = $urandom;
            m1_wstrb = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        s_ready  = 1'b0;
        s_rdata  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pref      = 0;
        to_sticky = 1'b0;
        #3;
    endtask

    // Runs one transaction from an IDLE cycle whose requests are already driven.
    // The slave answers on BUSY cycle 'lat' (never if lat > TO).
    task automatic run_txn(input int lat, input logic [31:0] sdata, input string tag);
        logic [1:0]  r;
        int          w;
        bit          done_ok, done_to;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_wstrb;
        r = {m1_valid, m0_valid};
        w = (r == 2'b11) ? pref : (r[1] ? 1 : 0);
        for (int k = 1; k <= TO; k++) begin
            next_cycle();
            done_ok = (k == lat);
            done_to = (k == TO) && !done_ok;
            s_ready = done_ok;
            s_rdata = done_ok ? sdata : (32'h5A5A_0000 + 32'(k));
            #3;
            exp_addr  = (w == 1) ? m1_addr  : m0_addr;
            exp_wdata = (w == 1) ? m1_wdata : m0_wdata;
            exp_wstrb = (w == 1) ? m1_wstrb : m0_wstrb;
            check_output({tag, "/grant"}, 32'(grant), (w == 1) ? 32'h2 : 32'h1);
            check_output({tag, "/s_valid"}, 32'(s_valid), 32'h1);
            check_output({tag, "/s_addr"}, s_addr, exp_addr);
            check_output({tag, "/s_wdata"}, s_wdata, exp_wdata);
            check_output({tag, "/s_wstrb"}, 32'(s_wstrb), 32'(exp_wstrb));
            check_output({tag, "/timeout"}, 32'(timeout), 32'(to_sticky));
            if (w == 0) begin
                check_output({tag, "/m0_ready"}, 32'(m0_ready), 32'(done_ok || done_to));
                check_output({tag, "/m1_ready"}, 32'(m1_ready), 32'h0);
                check_output({tag, "/m1_rdata"}, m1_rdata, 32'h0);
                if (done_ok || done_to)
                    check_output({tag, "/m0_rdata"}, m0_rdata, done_ok ? sdata : 32'hDEADBEEF);
            end else begin
                check_output({tag, "/m1_ready"}, 32'(m1_ready), 32'(done_ok || done_to));
                check_output({tag, "/m0_ready"}, 32'(m0_ready), 32'h0);
                check_output({tag, "/m0_rdata"}, m0_rdata, 32'h0);
                if (done_ok || done_to)
                    check_output({tag, "/m1_rdata"}, m1_rdata, done_ok ? sdata : 32'hDEADBEEF);
            end
            if (done_ok || done_to) begin
                to_sticky = to_sticky | done_to;
                pref      = 1 - w;
                break;
            end
        end
        next_cycle();
        s_ready = 1'b0;
        s_rdata = '0;
        if (w == 0) m0_valid = 1'b0;
        else        m1_valid = 1'b0;
        #3;
        check_output({tag, "/bubble_s_valid"}, 32'(s_valid), 32'h0);
        check_output({tag, "/bubble_grant"}, 32'(grant), 32'h0);
        check_output({tag, "/bubble_ready"}, 32'({m1_ready, m0_ready}), 32'h0);
        check_output({tag, "/bubble_timeout"}, 32'(timeout), 32'(to_sticky));
    endtask

    initial begin
        #2;
        check_output("rst/s_valid", 32'(s_valid), 32'h0);
        check_output("rst/grant", 32'(grant), 32'h0);
        check_output("rst/timeout", 32'(timeout), 32'h0);
        check_output("rst/ready", 32'({m1_ready, m0_ready}), 32'h0);
        check_output("rst/m0_rdata", m0_rdata, 32'h0);
        check_output("rst/s_addr", s_addr, 32'h0);
        apply_reset();

        // m0 read of 0x100, slave answers on the third BUSY cycle
        m0_addr = 32'h100; m0_wdata = 32'h0; m0_wstrb = 4'h0; m0_valid = 1'b1;
        #1;
        check_output("t1/req_cycle_s_valid", 32'(s_valid), 32'h0);
        run_txn(3, 32'h1234, "t1");

        // Tie after reset: m0, then m1, then m0 again
        apply_reset();
        apply_stimulus(0); apply_stimulus(1);
        m0_valid = 1'b1; m1_valid = 1'b1;
        run_txn(2, $urandom, "t2a");
        apply_stimulus(0); m0_valid = 1'b1;
        run_txn(1, $urandom, "t2b");
        apply_stimulus(1); m1_valid = 1'b1;
        run_txn(4, $urandom, "t2c");
        run_txn(1, $urandom, "t2d");

        // m1 write only
        m1_addr = 32'h200; m1_wdata = 32'hCAFEF00D; m1_wstrb = 4'hF; m1_valid = 1'b1;
        run_txn(5, $urandom, "t3");

        // Slave ready on the expiry cycle: data delivered, no timeout
        apply_reset();
        apply_stimulus(0); m0_valid = 1'b1;
        run_txn(TO, 32'h600D_D474, "t5");

        // Slave never answers, then a normal access
        apply_stimulus(0); m0_valid = 1'b1;
        run_txn(TO + 5, $urandom, "t4_timeout");
        apply_stimulus(0); m0_valid = 1'b1;
        run_txn(2, 32'h0BAD_CAFE, "t4_after");

        // Granted master abandons its request: no ready, pointer keeps pointing at m1
        apply_stimulus(0); m0_valid = 1'b1;
        run_txn(1, $urandom, "drop_pre");
        apply_stimulus(1); m1_valid = 1'b1;
        next_cycle();
        #3;
        check_output("drop/grant", 32'(grant), 32'h2);
        next_cycle();
        m1_valid = 1'b0;
        #3;
        check_output("drop/m1_ready", 32'({m1_ready, m0_ready}), 32'h0);
        next_cycle();
        #3;
        check_output("drop/idle_s_valid", 32'(s_valid), 32'h0);
        check_output("drop/idle_grant", 32'(grant), 32'h0);
        apply_stimulus(0); apply_stimulus(1);
        m0_valid = 1'b1; m1_valid = 1'b1;
        run_txn(2, $urandom, "drop_tie");
        m0_valid = 1'b0;
        #1;

        // Asynchronous reset in the middle of a BUSY access
        apply_stimulus(0); apply_stimulus(1);
        m0_valid = 1'b1;
        next_cycle();
        #3;
        check_output("t6/busy_grant", 32'(grant), 32'h1);
        #1 rst = 1'b1;
        pref      = 0;
        to_sticky = 1'b0;
        #1;
        check_output("t6/s_valid", 32'(s_valid), 32'h0);
        check_output("t6/grant", 32'(grant), 32'h0);
        check_output("t6/ready", 32'({m1_ready, m0_ready}), 32'h0);
        check_output("t6/timeout", 32'(timeout), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        m0_valid = 1'b1; m1_valid = 1'b1;
        run_txn(2, $urandom, "t6_tie");

        // Randomized traffic against the model
        for (int t = 0; t < 30; t++) begin
            if (!m0_valid && ($urandom_range(0, 1) == 1)) begin
                apply_stimulus(0); m0_valid = 1'b1;
            end
            if (!m1_valid && ($urandom_range(0, 1) == 1)) begin
                apply_stimulus(1); m1_valid = 1'b1;
            end
            if (!m0_valid && !m1_valid) begin
                apply_stimulus(0); m0_valid = 1'b1;
            end
            run_txn(int'($urandom_range(1, TO + 3)), $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
